// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package alu_seq_pkg;

  localparam int INSTR_W = 16;
  localparam int REG_AW  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  // Instruction word layout, MSB first: mode, func, rd, rs1, rs2, use_carry, no_wb.
  typedef struct packed {
    logic       mode;
    logic [3:0] func;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic       use_carry;
    logic       no_wb;
  } instr_t;

  // Bit positions inside the 6-bit flags word.
  localparam int FLAG_CARRY  = 5;
  localparam int FLAG_SIGN   = 4;
  localparam int FLAG_ZERO   = 3;
  localparam int FLAG_PARITY = 2;
  localparam int FLAG_EQUAL  = 1;
  localparam int FLAG_GT     = 0;

  // ALU mode and arithmetic function selects.
  localparam logic       MODE_LOGIC = 1'b0;
  localparam logic       MODE_ARITH = 1'b1;
  localparam logic [3:0] FN_ADD     = 4'h0;
  localparam logic [3:0] FN_SUB     = 4'h1;
  localparam logic [3:0] FN_INC     = 4'h2;
  localparam logic [3:0] FN_DEC     = 4'h3;
  localparam logic [3:0] FN_PASS_B  = 4'hE;
  localparam logic [3:0] FN_PASS_A  = 4'hF;

  function automatic logic [5:0] pack_flags(input logic c, input logic s, input logic z,
                                            input logic p, input logic e, input logic g);
    logic [5:0] f;
    f              = '0;
    f[FLAG_CARRY]  = c;
    f[FLAG_SIGN]   = s;
    f[FLAG_ZERO]   = z;
    f[FLAG_PARITY] = p;
    f[FLAG_EQUAL]  = e;
    f[FLAG_GT]     = g;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file, REG_CNT x DATA_W, two async read ports (third with ALU_SEQ_READ_PORT_EN).
// Latency: writes land on the clock edge; reads are combinational from current contents.
// Backpressure: none; write-back beats preload when both target the same entry.
module alu_seq_regfile
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              pl_en,
  input  logic [REG_AW-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_data,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data
`ifdef ALU_SEQ_READ_PORT_EN
  ,
  input  logic [REG_AW-1:0] rc_addr,
  output logic [DATA_W-1:0] rc_data
`endif
);

  logic [DATA_W-1:0] mem [REG_CNT];

  // Per-entry write: the sequencer's write-back has priority over an external preload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_CNT; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < REG_CNT; i++) begin
        if (wb_en && (wb_addr == REG_AW'(i)))      mem[i] <= wb_data;
        else if (pl_en && (pl_addr == REG_AW'(i))) mem[i] <= pl_data;
      end
    end
  end

  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
`ifdef ALU_SEQ_READ_PORT_EN
  assign rc_data = mem[rc_addr];
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one instruction to the ALU, waits ALU_LAT cycles, writes result/flags back (option: ALU_SEQ_READ_PORT_EN).
// Latency: accept at E0, ALU enable in cycle 1, done pulse in cycle 1+ALU_LAT; one op per ALU_LAT+2 cycles.
// Backpressure: instr_ready is high only in IDLE; no queueing, a held instr_valid waits for IDLE.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_CNT = 8,
  parameter int ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               wr_en,
  input  logic [REG_AW-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               alu_enable,
  output logic [DATA_W-1:0]  alu_in1,
  output logic [DATA_W-1:0]  alu_in2,
  output logic               alu_carry_in,
  output logic               alu_mode,
  output logic [3:0]         alu_func,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_carry_out,
  input  logic               alu_sign,
  input  logic               alu_zero,
  input  logic               alu_parity,
  input  logic               alu_equal,
  input  logic               alu_greater_than,
  output logic [5:0]         flags,
  output logic               done,
  output logic               busy
`ifdef ALU_SEQ_READ_PORT_EN
  ,
  input  logic [REG_AW-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data
`endif
);

  // Counter holds the remaining WAIT cycles minus one (at most ALU_LAT-2).
  localparam int CNT_W = (ALU_LAT > 2) ? $clog2(ALU_LAT - 1) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  instr_t             instr_w;
  logic               accept;
  logic [DATA_W-1:0]  rs1_data, rs2_data;
  logic [DATA_W-1:0]  op_a_q, op_b_q;
  logic               op_c_q, op_mode_q, op_no_wb_q;
  logic [3:0]         op_func_q;
  logic [REG_AW-1:0]  op_rd_q;
  logic [5:0]         flags_q;

  assign instr_w = instr_t'(instr);
  assign accept  = instr_valid && instr_ready;

  alu_seq_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk     (clk),
    .rst     (reset),
    .wb_en   ((state_q == ST_WB) && !op_no_wb_q),
    .wb_addr (op_rd_q),
    .wb_data (alu_result),
    .pl_en   (wr_en),
    .pl_addr (wr_addr),
    .pl_data (wr_data),
    .ra_addr (instr_w.rs1),
    .ra_data (rs1_data),
    .rb_addr (instr_w.rs2),
    .rb_data (rs2_data)
`ifdef ALU_SEQ_READ_PORT_EN
    ,
    .rc_addr (rd_addr),
    .rc_data (rd_data)
`endif
  );

  // State and WAIT down-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and state-decoded handshake/ALU strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_ready = 1'b0;
    alu_enable  = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        alu_enable = 1'b1;
        if (ALU_LAT > 1) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(ALU_LAT - 2);
        end else begin
          state_d = ST_WB;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_WB;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WB: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand snapshot at accept, so later preloads cannot disturb the in-flight op.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_c_q     <= 1'b0;
      op_mode_q  <= 1'b0;
      op_func_q  <= '0;
      op_rd_q    <= '0;
      op_no_wb_q <= 1'b0;
    end else if (accept) begin
      op_a_q     <= rs1_data;
      op_b_q     <= rs2_data;
      op_c_q     <= instr_w.use_carry & flags_q[FLAG_CARRY];
      op_mode_q  <= instr_w.mode;
      op_func_q  <= instr_w.func;
      op_rd_q    <= instr_w.rd;
      op_no_wb_q <= instr_w.no_wb;
    end
  end

  // Status flags captured on the write-back edge, even when the result is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (state_q == ST_WB) begin
      flags_q <= pack_flags(alu_carry_out, alu_sign, alu_zero,
                            alu_parity, alu_equal, alu_greater_than);
    end
  end

  assign alu_in1      = op_a_q;
  assign alu_in2      = op_b_q;
  assign alu_carry_in = op_c_q;
  assign alu_mode     = op_mode_q;
  assign alu_func     = op_func_q;
  assign flags        = flags_q;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/function interface.
- Accepts 16-bit ALU instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU's enable/in1/in2/carry_in/mode/func inputs, waits the ALU's registered latency, then captures result and flags.
- Writes the result back to the register file and the flags to a status register. Sits between the instruction decode stage and the ArithmeticLogicUnit.

Parameters:
- DATA_W, 16, operand/result width.
- REG_CNT, 8, register file depth (address width = 3).
- ALU_LAT, 1, cycles from an ALU enable edge to a valid result (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- instr_valid  in  1  instruction word present.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  16  instruction word:
  - [15] mode, [14:11] func, [10:8] rd, [7:5] rs1, [4:2] rs2.
  - [1] use_carry: carry_in = stored carry flag, else 0.
  - [0] no_wb: flags only, rd not written.
- wr_en  in  1  external register preload strobe.
- wr_addr  in  3  preload address.
- wr_data  in  DATA_W  preload data.
- alu_enable  out  1  ALU enable.
- alu_in1  out  DATA_W  ALU operand 1.
- alu_in2  out  DATA_W  ALU operand 2.
- alu_carry_in  out  1  ALU carry in.
- alu_mode  out  1  ALU mode.
- alu_func  out  4  ALU function select.
- alu_result  in  DATA_W  ALU result.
- alu_carry_out, alu_sign, alu_zero, alu_parity, alu_equal, alu_greater_than  in  1 each  ALU flags.
- flags  out  6  {carry,sign,zero,parity,equal,greater_than}, registered.
- done  out  1  one-cycle pulse on commit.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, all registers=0, flags=0, alu_* outputs=0, done=0, busy=0, instr_ready=1 after reset deasserts.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE: instr_ready=1. instr_valid&instr_ready at edge E0 latches instr, rs1/rs2 data and carry flag into operand registers; next state ISSUE.
- ISSUE (1 cycle): alu_enable=1. alu_in1/in2/carry_in/mode/func come from latched registers. Next state WAIT if ALU_LAT>1, else WB.
- WAIT: lasts ALU_LAT-1 cycles via down-counter; alu_enable=0; operands held stable.
- WB (1 cycle): done=1; samples alu_result and flags.
  - Closing edge writes flags register.
  - Closing edge writes reg[rd] unless no_wb=1.
  - Next state IDLE.
- Latency: accept at E0, ISSUE in cycle 1, WB in cycle 1+ALU_LAT. Throughput is one instruction per ALU_LAT+2 cycles.
- alu_enable is never high outside ISSUE. alu_in1/in2/mode/func stay constant from ISSUE through WB.
- Operand snapshot is taken at accept: preloads to rs1/rs2 after E0 do not affect the in-flight op.
- Preload may occur in any state.
  - Preload and WB to the same address on the same edge: WB wins.
  - Different addresses: both written.
- rs1==rs2 and rd==rs1 are legal.
- instr_valid held high while busy is ignored; no queueing.
- Data passes through unmodified: sign-magnitude arithmetic is the ALU's concern.

Optional Feature:
- Macro ALU_SEQ_READ_PORT_EN.
- Defined: adds ports rd_addr (in, 3) and rd_data (out, DATA_W). rd_data = reg[rd_addr] combinationally, showing the post-edge value; no bypass of same-cycle writes.
- Undefined: the ports do not exist and register contents are observable only via ALU results.

Decomposition:
- Package alu_seq_pkg: state encoding (IDLE/ISSUE/WAIT/WB), instr field bit positions, flag bit indices, ALU mode/func constants (ADD=0, SUB=1, INC=2, DEC=3, PASS_B=E, PASS_A=F).
- One natural sub-module, alu_seq_regfile: 8x16, async reset, two read ports, write port with WB-over-preload priority. FSM and ALU drive stay in the top.

Test Plan:
- Preload r1=0x0007, r2=0x0006; instr mode=1 func=0 rd=3 rs1=1 rs2=2 -> done in cycle 1+ALU_LAT after accept; r3=0x000D, zero=0, sign=0; alu_enable high exactly one cycle.
- r1=0x8009 (-9), r2=0x0009, add, rd=4 -> r4 magnitude 0, flags.zero=1. Repeat with no_wb=1 on r5 -> r5 unchanged, flags still updated.
- During WAIT (ALU_LAT=3), preload r1=0xFFFF -> in-flight result uses old r1. Preload r3 on the WB edge with rd=3 -> r3 holds the ALU result.
- Hold instr_valid high for 10 cycles -> instr_ready low while busy. Instructions are accepted only in IDLE, one per ALU_LAT+2 cycles, and no instruction is dropped or duplicated.
- Assert reset during WAIT -> outputs and registers 0 immediately (async), done never pulses, IDLE/instr_ready=1 after release.
- Logical mode=0, funcs 0..7 on 0xAB70/0xF086 -> each rd matches the ALU reference model. With ALU_SEQ_READ_PORT_EN, rd_data reflects each write on the following cycle.
